regfile_wb_arbiter: RTL
=======================

Name: regfile_wb_arbiter

Overview:
- Write-back controller in front of the 16x16 register file's single write port.
- Arbitrates write-back requests from the ALU (requester A) and the load/store unit (requester B) with round-robin priority.
- Drives the register file write port from registered outputs.
- Keeps a pending-write scoreboard and raises a stall to decode when a source or destination register has an uncommitted write.

Parameters:
- NREG, 16, number of architectural registers (scoreboard bits).
- AW, 4, register address width (log2 NREG).
- DW, 16, data width.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- i_a_valid  in  1  ALU write-back request.
- i_a_add  in  AW  ALU destination register.
- i_a_data  in  DW  ALU result.
- o_a_ready  out  1  ALU request accepted this cycle.
- i_b_valid  in  1  LSU write-back request.
- i_b_add  in  AW  LSU destination register.
- i_b_data  in  DW  LSU load data.
- o_b_ready  out  1  LSU request accepted this cycle.
- i_issue_valid  in  1  decode issuing an instruction that will write i_issue_add.
- i_issue_add  in  AW  destination of the issuing instruction.
- i_read_add1  in  AW  source 1 of the instruction in decode.
- i_read_add2  in  AW  source 2 of the instruction in decode.
- i_use_add2  in  1  source 2 is a register; 0 for the immediate form, so source 2 is not checked.
- o_stall  out  1  decode must hold; the issue is not taken.
- o_write_en  out  1  register file write enable (registered).
- o_write_add  out  AW  register file write address (registered).
- o_write_data  out  DW  register file write data (registered).
- o_pending  out  NREG  scoreboard contents, for debug.
- o_wb_unexpected  out  1  one-cycle pulse: a write-back committed to a non-pending register.

Behaviour:
- Reset (synchronous, active-high; takes effect on any edge, including mid-transfer):
  - o_write_en=0, o_write_add=0, o_write_data=0.
  - o_pending=0, o_wb_unexpected=0.
  - Round-robin pointer = A.
  - Any request accepted in the reset cycle is discarded.
- Handshake:
  - A requester holds valid, add and data stable until its ready is seen high.
  - Ready is combinational from both valids and the pointer.
  - At most one ready is high per cycle.
  - Ready is never high without its own valid.
- Arbitration:
  - Only one valid: that requester is granted.
  - Both valid: the pointer side is granted, then the pointer moves to the other side.
  - The pointer updates only on a grant.
  - Worst-case wait with the other side continuously valid: 1 cycle.
- Write-back latency:
  - A grant in cycle N gives o_write_en=1 in cycle N+1, with the add/data captured at N.
  - No grant in N gives o_write_en=0 in N+1.
  - o_write_en is a single-cycle pulse per grant; back-to-back grants give consecutive pulses.
- Scoreboard:
  - Set: pending[i_issue_add] is set on the edge where i_issue_valid=1 and o_stall=0.
  - Clear: pending[grant add] is cleared on the edge ending grant cycle N, so the bit reads 0 in N+1.
  - The register file commits on the falling edge within N+1, so decode released in N+1 reads the new value in the same cycle.
- Stall (combinational), high when i_issue_valid=1 and any of:
  - pending[i_read_add1]=1;
  - i_use_add2=1 and pending[i_read_add2]=1;
  - pending[i_issue_add]=1 (WAW).
- Simultaneous events:
  - Set and clear of the same address on one edge: set wins, and the bit stays 1.
  - Set and clear of different addresses apply independently.
- Unexpected write-back:
  - A grant to an address whose pending bit is 0 still writes the register file.
  - The scoreboard is unchanged.
  - o_wb_unexpected pulses in N+1.
- All scoreboard indexing uses AW bits; there are no out-of-range addresses.

Decomposition:
- Package regfile_pkg holds:
  - constants NREG, AW, DW;
  - requester enum {REQ_A, REQ_B};
  - the write-back request struct {add, data}.
- Sub-module rr_arbiter2 contains the 2-way round-robin grant logic and pointer register.
- The scoreboard, stall logic and output registers stay in the top-level block.

Test Plan:
- Reset with a request active: assert reset while i_a_valid=1 -> next cycle o_write_en=0, o_pending=0, no write, and o_a_ready low during reset.
- Single write-back: issue r5, then A valid add=5 data=16'h1234 -> o_a_ready in cycle N; o_write_en=1, add=5, data=16'h1234 in N+1; pending[5] reads 0 in N+1.
- Contention and fairness: A and B both valid for 4 cycles (A add=1/2, B add=3/4) -> grants alternate A,B,A,B; write pulses on 4 consecutive cycles.
- RAW stall release: issue r7, then decode reads r7 -> o_stall=1 until the r7 write-back grant; o_stall=0 in the write cycle.
- Immediate form: pending[2]=1, i_read_add2=2, i_use_add2=0, read_add1 not pending -> o_stall=0; with i_use_add2=1 -> o_stall=1.
- Unexpected write-back and same-cycle set/clear:
  - B writes non-pending r9 -> r9 written, o_wb_unexpected pulses once.
  - Issue r4 on the same edge as an r4 write-back grant -> pending[4]=1 afterwards.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file write-back controller.
//   NREG/AW/DW : register count, address width, data width
//   req_e      : requester identity (ALU = REQ_A, LSU = REQ_B)
//   wb_req_t   : one write-back request {add, data}
package regfile_pkg;

  localparam int NREG = 16;
  localparam int AW   = 4;
  localparam int DW   = 16;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_e;

  typedef struct packed {
    logic [AW-1:0] add;
    logic [DW-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter with a registered priority pointer.
//   clk, reset       : clock, synchronous active-high reset (pointer -> REQ_A)
//   a_valid_i/b_valid_i : request lines
//   a_gnt_o/b_gnt_o  : combinational grants, mutually exclusive, held low in reset
module rr_arbiter2
  import regfile_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic a_valid_i,
  input  logic b_valid_i,
  output logic a_gnt_o,
  output logic b_gnt_o
);

  req_e ptr_q, ptr_d;

  // A lone requester always wins; on contention the pointer side wins.
  // Grants are suppressed during reset so nothing is accepted that would
  // then be thrown away.
  always_comb begin
    a_gnt_o = !reset && a_valid_i && (!b_valid_i || ptr_q == REQ_A);
    b_gnt_o = !reset && b_valid_i && (!a_valid_i || ptr_q == REQ_B);
  end

  // Pointer moves to the side that did not win, and only on a grant.
  always_comb begin
    ptr_d = ptr_q;
    if (a_gnt_o)      ptr_d = REQ_B;
    else if (b_gnt_o) ptr_d = REQ_A;
  end

  always_ff @(posedge clk) begin
    if (reset) ptr_q <= REQ_A;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back controller for the single register-file write port.
// Arbitrates ALU (A) and LSU (B) write-backs round-robin, drives the write
// port from registers one cycle after the grant, and tracks pending writes
// in a scoreboard used to stall decode on RAW/WAW hazards.
//   clk, reset                 : clock, synchronous active-high reset
//   i_a_* / o_a_ready          : ALU write-back request / accept
//   i_b_* / o_b_ready          : LSU write-back request / accept
//   i_issue_valid, i_issue_add : decode issuing a writer of i_issue_add
//   i_read_add1/2, i_use_add2  : decode sources (source 2 optional)
//   o_stall                    : decode must hold this cycle
//   o_write_en/add/data        : registered register-file write port
//   o_pending                  : scoreboard contents
//   o_wb_unexpected            : write-back landed on a non-pending register
module regfile_wb_arbiter
  import regfile_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            i_a_valid,
  input  logic [AW-1:0]   i_a_add,
  input  logic [DW-1:0]   i_a_data,
  output logic            o_a_ready,
  input  logic            i_b_valid,
  input  logic [AW-1:0]   i_b_add,
  input  logic [DW-1:0]   i_b_data,
  output logic            o_b_ready,
  input  logic            i_issue_valid,
  input  logic [AW-1:0]   i_issue_add,
  input  logic [AW-1:0]   i_read_add1,
  input  logic [AW-1:0]   i_read_add2,
  input  logic            i_use_add2,
  output logic            o_stall,
  output logic            o_write_en,
  output logic [AW-1:0]   o_write_add,
  output logic [DW-1:0]   o_write_data,
  output logic [NREG-1:0] o_pending,
  output logic            o_wb_unexpected
);

  logic            a_gnt, b_gnt, gnt;
  wb_req_t         gnt_req;
  logic            wen_q;
  wb_req_t         wr_q;
  logic [NREG-1:0] pending_q, pending_d;
  logic            unexp_q;
  logic            issue_take;

  rr_arbiter2 u_arb (
    .clk       (clk),
    .reset     (reset),
    .a_valid_i (i_a_valid),
    .b_valid_i (i_b_valid),
    .a_gnt_o   (a_gnt),
    .b_gnt_o   (b_gnt)
  );

  assign o_a_ready = a_gnt;
  assign o_b_ready = b_gnt;
  assign gnt       = a_gnt | b_gnt;

  always_comb begin
    gnt_req.add  = i_a_add;
    gnt_req.data = i_a_data;
    if (b_gnt) begin
      gnt_req.add  = i_b_add;
      gnt_req.data = i_b_data;
    end
  end

  // Hazard check against the registered scoreboard. A write-back granted
  // this cycle clears its bit at the edge, so decode is released in the
  // write cycle, when the register file commits on the falling edge.
  always_comb begin
    o_stall = i_issue_valid &&
              (pending_q[i_read_add1] ||
               (i_use_add2 && pending_q[i_read_add2]) ||
               pending_q[i_issue_add]);
  end

  assign issue_take = i_issue_valid && !o_stall;

  // Clear first, then set, so a same-address set/clear leaves the bit set.
  always_comb begin
    pending_d = pending_q;
    if (gnt)        pending_d[gnt_req.add]  = 1'b0;
    if (issue_take) pending_d[i_issue_add] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wen_q     <= 1'b0;
      wr_q      <= '0;
      pending_q <= '0;
      unexp_q   <= 1'b0;
    end else begin
      wen_q     <= gnt;
      if (gnt) wr_q <= gnt_req;
      pending_q <= pending_d;
      unexp_q   <= gnt && !pending_q[gnt_req.add];
    end
  end

  assign o_write_en      = wen_q;
  assign o_write_add     = wr_q.add;
  assign o_write_data    = wr_q.data;
  assign o_pending       = pending_q;
  assign o_wb_unexpected = unexp_q;

endmodule
